// File: rtl/inst_buffer.sv
// Circular instruction queue between fetch and dispatch, squashable in one cycle.
// Latency: an enqueued instruction is visible on ib_* the cycle after it is accepted.
// Backpressure: a fetch group is taken whole or not at all (if_accept); dispatch takes up to dis_num.
module inst_buffer #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 2
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               squash,
    input  logic [WIDTH-1:0]                   if_valid,
    input  logic [WIDTH-1:0][31:0]             if_inst,
    input  logic [WIDTH-1:0][31:0]             if_pc,
    input  logic [WIDTH-1:0][31:0]             if_npc,
    output logic                               if_accept,
    input  logic [$clog2(WIDTH+1)-1:0]         dis_num,
    output logic [WIDTH-1:0]                   ib_valid,
    output logic [WIDTH-1:0][31:0]             ib_inst,
    output logic [WIDTH-1:0][31:0]             ib_pc,
    output logic [WIDTH-1:0][31:0]             ib_npc,
    output logic [$clog2(DEPTH+1)-1:0]         free_slots,
    output logic                               ib_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int NW = $clog2(WIDTH+1);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] npc;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;
    logic [NW-1:0]   n_in;
    logic [CW-1:0]   n_out;

    // Only the contiguous run of valid lanes starting at lane 0 counts.
    always_comb begin
        logic stop;
        n_in = '0;
        stop = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            if (!stop && if_valid[k]) n_in = n_in + NW'(1);
            else                      stop = 1'b1;
        end
    end

    assign free_slots = CW'(DEPTH) - count;
    assign ib_empty   = (count == '0);
    assign if_accept  = !reset && !squash && (n_in != '0) && (CW'(n_in) <= free_slots);
    assign n_out      = (CW'(dis_num) > count) ? count : CW'(dis_num);

    always_ff @(posedge clock) begin
        if (reset || squash) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (if_accept) tail <= tail + PW'(n_in);
            head  <= head + PW'(n_out);
            count <= count + (if_accept ? CW'(n_in) : CW'(0)) - n_out;
        end
    end

    // Entry storage carries no reset; if_accept already excludes reset and squash.
    always_ff @(posedge clock) begin
        if (if_accept) begin
            for (int k = 0; k < WIDTH; k++) begin
                if (NW'(k) < n_in) begin
                    mem[tail + PW'(k)] <= '{inst: if_inst[k], pc: if_pc[k], npc: if_npc[k]};
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            ib_valid[i] = 1'b0;
            ib_inst[i]  = '0;
            ib_pc[i]    = '0;
            ib_npc[i]   = '0;
            if (CW'(i) < count) begin
                ib_valid[i] = 1'b1;
                ib_inst[i]  = mem[head + PW'(i)].inst;
                ib_pc[i]    = mem[head + PW'(i)].pc;
                ib_npc[i]   = mem[head + PW'(i)].npc;
            end
        end
    end

endmodule
